// File: rtl/router_pkt_src.sv
// Packet source that feeds a router: header {len,addr}, LFSR payload bytes, then an XOR parity byte.
// Every output is decoded from registered state so busy/start never reach an output combinationally.
module router_pkt_src (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] dest_addr,
  input  logic [5:0] pld_len,
  input  logic [7:0] seed,
  input  logic       busy,
  output logic [7:0] datain,
  output logic       packet_valid,
  output logic       ready,
  output logic       done,
  output logic       cfg_err,
  output logic [7:0] pkt_cnt
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HEADER  = 3'd1,
    PAYLOAD = 3'd2,
    PARITY  = 3'd3,
    GAP     = 3'd4
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [1:0] addr_q;
  logic [5:0] len_q;
  logic [7:0] lfsr;
  logic [7:0] lfsr_next;
  logic [7:0] parity;
  logic [5:0] byte_cnt;
  logic [7:0] cnt_q;
  logic       cfg_err_q;
  logic       start_legal;
  logic       last_payload;
  logic [7:0] header_byte;

  assign start_legal  = (dest_addr != 2'b11) && (pld_len != 6'd0);
  assign lfsr_next    = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign last_payload = (byte_cnt == (len_q - 6'd1));
  assign header_byte  = {len_q, addr_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A byte-carrying state only advances on a cycle the router accepts it (busy=0).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start && start_legal) state_next = HEADER;
      HEADER:  if (!busy) state_next = PAYLOAD;
      PAYLOAD: if (!busy && last_payload) state_next = PARITY;
      PARITY:  if (!busy) state_next = GAP;
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q    <= 2'd0;
      len_q     <= 6'd0;
      lfsr      <= 8'h01;
      parity    <= 8'h00;
      byte_cnt  <= 6'd0;
      cnt_q     <= 8'h00;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= (state == IDLE) && start && !start_legal;
      case (state)
        IDLE: begin
          if (start && start_legal) begin
            addr_q   <= dest_addr;
            len_q    <= pld_len;
            lfsr     <= (seed == 8'h00) ? 8'h01 : seed;
            parity   <= 8'h00;
            byte_cnt <= 6'd0;
          end
        end
        HEADER: begin
          if (!busy) parity <= header_byte;
        end
        PAYLOAD: begin
          if (!busy) begin
            parity   <= parity ^ lfsr;
            lfsr     <= lfsr_next;
            byte_cnt <= byte_cnt + 6'd1;
          end
        end
        GAP: begin
          // Counter wraps silently at 8 bits.
          cnt_q <= cnt_q + 8'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    datain       = 8'h00;
    packet_valid = 1'b0;
    case (state)
      HEADER: begin
        datain       = header_byte;
        packet_valid = 1'b1;
      end
      PAYLOAD: begin
        datain       = lfsr;
        packet_valid = 1'b1;
      end
      PARITY: datain = parity;
      default: ;
    endcase
  end

  assign ready   = (state == IDLE);
  assign done    = (state == GAP);
  assign cfg_err = cfg_err_q;
  assign pkt_cnt = cnt_q;

endmodule

// File: doc/router_pkt_src.md
ROUTER_PKT_SRC -- requirements
Module: router_pkt_src

Interface
REQ-001 SHALL have a single clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous active-high reset, sampled on clk rising edge.
REQ-004 start  input  1  one-cycle request to send one packet; honoured only when ready=1.
REQ-005 dest_addr  input  2  destination port for the requested packet; 0..2 legal.
REQ-006 pld_len  input  6  payload byte count for the requested packet; 1..63 legal.
REQ-007 seed  input  8  payload LFSR seed, loaded on accepted start.
REQ-008 busy  input  1  router back-pressure; byte on datain is NOT accepted in any cycle where busy=1.
REQ-009 datain  output  8  byte driven into the router.
REQ-010 packet_valid  output  1  high during header and payload bytes, low during the parity byte.
REQ-011 ready  output  1  high only in IDLE.
REQ-012 done  output  1  one-cycle pulse after the parity byte is accepted.
REQ-013 cfg_err  output  1  one-cycle pulse when a start carries illegal dest_addr or pld_len.
REQ-014 pkt_cnt  output  8  count of completed packets.

Function
REQ-015 SHALL implement FSM states IDLE, HEADER, PAYLOAD, PARITY, GAP.
REQ-016 All outputs SHALL be functions of registered state only; no combinational path from busy or start to any output.
REQ-017 A byte SHALL count as accepted at a rising edge where state is HEADER/PAYLOAD/PARITY and busy=0; while busy=1, datain, packet_valid, state, LFSR and parity SHALL hold.
REQ-018 IDLE: datain=8'h00, packet_valid=0, ready=1; start=1 with legal dest_addr and pld_len SHALL latch addr, len, seed and enter HEADER next cycle.
REQ-019 start with dest_addr=2'b11 or pld_len=0 SHALL stay IDLE and pulse cfg_err the following cycle; start outside IDLE SHALL be ignored with no cfg_err.
REQ-020 HEADER: datain={len,addr}, packet_valid=1; on acceptance parity register SHALL load the header value and state SHALL go to PAYLOAD.
REQ-021 LFSR: 8-bit; seed 8'h00 SHALL be replaced by 8'h01 on load; advance rule lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
REQ-022 PAYLOAD: datain=current lfsr, packet_valid=1; on each acceptance parity ^= datain, LFSR advances, byte counter increments; after len-th acceptance state SHALL go to PARITY.
REQ-023 PARITY: datain=parity (XOR of header and all payload bytes), packet_valid=0; on acceptance state SHALL go to GAP.
REQ-024 GAP: exactly one cycle, datain=8'h00, packet_valid=0, done=1, pkt_cnt increments; then IDLE.
REQ-025 pkt_cnt SHALL wrap 8'hFF -> 8'h00 without error indication.
REQ-026 With busy=0 throughout, start at edge N SHALL give header in cycle N+1, payload cycles N+2..N+1+len, parity at N+2+len, done at N+3+len, ready at N+4+len.

Reset
REQ-027 reset=1 at any rising edge, including mid-packet, SHALL force IDLE, datain=8'h00, packet_valid=0, ready=1, done=0, cfg_err=0, pkt_cnt=0, parity=0, byte counter=0, lfsr=8'h01.
REQ-028 reset SHALL take priority over start and busy in the same cycle; an aborted packet SHALL NOT increment pkt_cnt or pulse done.

Verification
REQ-029 reset, start with addr=0, len=1, seed=8'h01, busy=0 -> datain 8'h04,8'h01,8'h05; packet_valid 1,1,0; done next cycle; pkt_cnt=1.
REQ-030 start addr=2, len=2, seed=8'h00, busy=0 -> datain 8'h0A,8'h01,8'h02,8'h09; parity byte with packet_valid=0.
REQ-031 addr=1, len=20; busy held high 3 cycles during header and 2 cycles mid-payload -> header 8'h51 held stable while busy, no byte skipped or repeated, parity equals XOR of observed accepted bytes.
REQ-032 start with addr=3 and, separately, len=0 -> cfg_err one-cycle pulse each, ready stays 1, packet_valid stays 0, pkt_cnt unchanged.
REQ-033 reset asserted during PAYLOAD byte 5 of a len=10 packet -> next cycle packet_valid=0, ready=1, pkt_cnt=0, no done; fresh start then sends a complete correct packet.
REQ-034 start pulsed during PAYLOAD, and 256 back-to-back len=1 packets -> mid-packet start ignored; pkt_cnt wraps to 8'h00 after packet 256.
